dmem_responder: RTL and testbench

- Data-memory responder serving the CPU's MEM-stage data port (dmem_addr/dmem_we/dmem_wdata in, dmem_rdata out).
- Holds word-addressed data RAM plus an MMIO window: LED register, synchronized switch input, byte-wide TX FIFO with valid/ready output, and a cycle counter.
- Sits beside the CPU at top level. The CPU's store unit already merges sub-word stores into full words, so this block sees only full-word accesses.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_responder_tx_byte_fifo.sv | 70 +++++++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder:
// MMIO register offsets, TX_STATUS bit layout and the default MMIO window.
package dmem_pkg;

    localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'hFFFF;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_TXSTAT = 8'h0C;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 7;

    // Occupancy field is four bits wide; larger FIFOs report 15.
    function automatic logic [3:0] sat_nibble(input logic [31:0] value);
        logic [3:0] result;
        if (value > 32'd15) begin
            result = 4'hF;
        end else begin
            result = value[3:0];
        end
        return result;
    endfunction

    // Assemble the TX_STATUS read word; unused bits read as zero.
    function automatic logic [31:0] tx_status_word(input logic       full,
                                                   input logic       empty,
                                                   input logic       ovf,
                                                   input logic [3:0] cnt);
        logic [31:0] word;
        word                         = 32'h0000_0000;
        word[ST_FULL]                = full;
        word[ST_EMPTY]               = empty;
        word[ST_OVF]                 = ovf;
        word[ST_CNT_MSB:ST_CNT_LSB]  = cnt;
        return word;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_byte_fifo.sv
// Byte-wide TX FIFO. A push into a full FIFO is still accepted when a pop
// happens in the same cycle, so the head can stream at full rate.
module tx_byte_fifo #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             push_accepted
);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pop_ok_s;

    assign empty         = (cnt_r == {CNT_W{1'b0}});
    assign full          = (cnt_r == CNT_W'(DEPTH));
    assign count         = cnt_r;
    // A pop request against an empty FIFO is a no-op.
    assign pop_ok_s      = pop && !empty;
    assign push_accepted = push && (!full || pop_ok_s);

    // Pointer and occupancy bookkeeping; reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_accepted) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_accepted, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Byte storage; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push_accepted) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head byte, forced to zero while empty so stale data never leaks out.
    always_comb begin
        if (empty) begin
            head = 8'h00;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: word RAM plus an MMIO window
// holding LEDs, synchronized switches, a TX byte FIFO and a cycle counter.
// Reads are combinational; writes commit on clk when dmem_we && global_en.
module dmem_responder import dmem_pkg::*; #(
    parameter int          ADDR_W       = 10,
    parameter int          TX_DEPTH     = 8,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        global_en,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_we,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    logic [31:0]       ram_r [2**ADDR_W];
    logic [15:0]       led_r;
    logic [15:0]       sw_meta_r;
    logic [15:0]       sw_sync_r;
    logic [31:0]       cycle_r;
    logic              ovf_r;

    logic              is_mmio_s;
    logic [7:0]        off_s;
    logic [ADDR_W-1:0] ram_idx_s;
    logic              wr_en_s;
    logic              wr_mmio_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              push_acc_s;
    logic [31:0]       rdata_s;
    logic              unused_addr_s;

    // Low address bits select the word; bits above the RAM index alias.
    assign is_mmio_s     = (dmem_addr[31:16] == MMIO_BASE_HI);
    assign off_s         = {dmem_addr[7:2], 2'b00};
    assign ram_idx_s     = dmem_addr[ADDR_W+1:2];
    assign unused_addr_s = ^dmem_addr;

    assign wr_en_s   = dmem_we && global_en;
    assign wr_mmio_s = wr_en_s && is_mmio_s;
    assign push_s    = wr_mmio_s && (off_s == OFF_TXDATA);
    // Draining is independent of global_en so the UART side keeps moving.
    assign pop_s     = tx_valid && tx_ready;

    tx_byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push_s),
        .push_data     (dmem_wdata[7:0]),
        .pop           (pop_s),
        .head          (tx_data),
        .full          (fifo_full_s),
        .empty         (fifo_empty_s),
        .count         (fifo_count_s),
        .push_accepted (push_acc_s)
    );

    assign tx_valid   = !fifo_empty_s;
    assign led_out    = led_r;
    assign dmem_rdata = rdata_s;

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !is_mmio_s) begin
            ram_r[ram_idx_s] <= dmem_wdata;
        end
    end

    // LED register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 16'h0000;
        end else if (wr_mmio_s && (off_s == OFF_LED)) begin
            led_r <= dmem_wdata[15:0];
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_r <= 16'h0000;
            sw_sync_r <= 16'h0000;
        end else begin
            sw_meta_r <= sw_in;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Free-running cycle counter; a CPU load wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r <= 32'h0000_0000;
        end else if (wr_mmio_s && (off_s == OFF_CYCLE)) begin
            cycle_r <= dmem_wdata;
        end else if (global_en) begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by writing bit 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (push_s && !push_acc_s) begin
            ovf_r <= 1'b1;
        end else if (wr_mmio_s && (off_s == OFF_TXSTAT) && dmem_wdata[ST_OVF]) begin
            ovf_r <= 1'b0;
        end
    end

    // Zero-latency read mux across RAM and the MMIO registers.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (is_mmio_s) begin
            case (off_s)
                OFF_LED:    rdata_s = {16'h0000, led_r};
                OFF_SW:     rdata_s = {16'h0000, sw_sync_r};
                OFF_TXSTAT: rdata_s = tx_status_word(fifo_full_s, fifo_empty_s, ovf_r,
                                                     sat_nibble(32'(fifo_count_s)));
                OFF_CYCLE:  rdata_s = cycle_r;
                default:    rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = ram_r[ram_idx_s];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: each stimulus cycle pushes the expected
// read word into a queue, accepted TX bytes go into a byte queue, and a monitor
// on the falling edge pops and compares whenever the DUT presents output.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        global_en;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .global_en  (global_en),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state (behavioural, spec level).
    logic [31:0] m_ram [int];
    logic [15:0] m_led;
    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    logic [31:0] m_cycle;
    logic [15:0] m_sw_hist [$];   // sw_in sampled at each clock edge

    typedef struct {
        logic [31:0] exp;
        bit          valid;
        string       name;
    } rd_t;

    rd_t        rd_q [$];
    logic [7:0] exp_tx [$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_led = 16'h0000;
        m_fifo.delete();
        exp_tx.delete();
        m_ovf = 1'b0;
        m_cycle = 32'h0;
        m_sw_hist.delete();
    endfunction

    // Switch value visible to the CPU: whatever sw_in was two edges ago.
    function automatic logic [15:0] model_sw();
        int n = m_sw_hist.size();
        if (n >= 2) return m_sw_hist[n-2];
        return 16'h0000;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit v);
        logic [31:0] r;
        int cnt;
        v = 1'b1;
        r = 32'h0;
        if (a[31:16] == 16'hFFFF) begin
            case (a[7:0] & 8'hFC)
                8'h00: r = {16'h0, m_led};
                8'h04: r = {16'h0, model_sw()};
                8'h0C: begin
                    cnt  = m_fifo.size();
                    r[0] = (cnt == 8);
                    r[1] = (cnt == 0);
                    r[2] = m_ovf;
                    r[7:4] = (cnt > 15) ? 4'hF : 4'(cnt);
                end
                8'h10: r = m_cycle;
                default: r = 32'h0;
            endcase
        end else if (m_ram.exists(int'(a[11:2]))) begin
            r = m_ram[int'(a[11:2])];
        end else begin
            v = 1'b0;
        end
        return r;
    endfunction

    // Apply one clock edge worth of spec behaviour to the model.
    function automatic void model_update();
        bit          wr   = dmem_we && global_en;
        bit          mmio = (dmem_addr[31:16] == 16'hFFFF);
        logic [7:0]  off  = dmem_addr[7:0] & 8'hFC;
        int          sz   = m_fifo.size();
        bit          pop  = (sz > 0) && tx_ready;
        bit          push = wr && mmio && (off == 8'h08);
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (sz < 8 || pop) begin
                m_fifo.push_back(dmem_wdata[7:0]);
                exp_tx.push_back(dmem_wdata[7:0]);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (wr && mmio && off == 8'h0C && dmem_wdata[2]) m_ovf = 1'b0;
        if (wr && mmio && off == 8'h10) m_cycle = dmem_wdata;
        else if (global_en) m_cycle = m_cycle + 32'd1;
        if (wr && mmio && off == 8'h00) m_led = dmem_wdata[15:0];
        if (wr && !mmio) m_ram[int'(dmem_addr[11:2])] = dmem_wdata;
        m_sw_hist.push_back(sw_in);
        if (m_sw_hist.size() > 4) void'(m_sw_hist.pop_front());
    endfunction

    // One clock of stimulus: queue the expected read, advance model, cross edge.
    task automatic step(input bit use_c = 1'b0, input logic [31:0] c = 32'h0,
                        input string nm = "rd");
        rd_t e;
        bit  v;
        e.exp   = model_read(dmem_addr, v);
        e.valid = v;
        e.name  = nm;
        if (use_c) begin
            e.exp   = c;
            e.valid = 1'b1;
        end
        rd_q.push_back(e);
        @(negedge clk);
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, (m_fifo.size() != 0)});
        chk("led_out", {16'h0, led_out}, {16'h0, m_led});
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm = "wr_rd");
        dmem_we    = 1'b1;
        dmem_addr  = a;
        dmem_wdata = d;
        step(1'b0, 32'h0, nm);
        dmem_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] c, input string nm);
        dmem_we   = 1'b0;
        dmem_addr = a;
        step(1'b1, c, nm);
    endtask

    // Monitor: compare read data and TX handshakes against the queues.
    always @(negedge clk) begin
        rd_t e;
        if (rst_n) begin
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                if (e.valid) chk(e.name, dmem_rdata, e.exp);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
                end else begin
                    chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_SW   = 32'hFFFF_0004;
    localparam logic [31:0] A_TXD  = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT = 32'hFFFF_000C;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0010;

    initial begin
        logic [31:0] cv;
        logic [7:0]  offs [6];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};

        rst_n = 1'b0; global_en = 1'b0; dmem_we = 1'b0;
        dmem_addr = 32'h0; dmem_wdata = 32'h0; sw_in = 16'h0; tx_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        rd(A_STAT, 32'h0000_0002, "rst_status");
        rd(A_CYC, 32'h0, "rst_cycle");

        // RAM write/read with aliasing
        global_en = 1'b1;
        wr(32'h0000_0040, 32'hDEAD_BEEF);
        rd(32'h0000_0040, 32'hDEAD_BEEF, "ram_read");
        rd(32'h0000_1040, 32'hDEAD_BEEF, "ram_alias");

        // global_en gating
        global_en = 1'b0;
        wr(32'h0000_0040, 32'h1234_5678);
        wr(A_LED, 32'h0000_5A5A);
        rd(32'h0000_0040, 32'hDEAD_BEEF, "gated_ram");
        rd(A_LED, 32'h0, "gated_led");
        cv = m_cycle;
        repeat (5) rd(A_CYC, cv, "cycle_frozen");
        global_en = 1'b1;

        // FIFO fill and overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(A_TXD, 32'(i));
        rd(A_STAT, 32'h0000_0085, "fill_status");
        chk("fill_head", {24'h0, tx_data}, 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, "drain_status");
        chk("drain_left", 32'(exp_tx.size()), 32'h0);
        rd(A_STAT, 32'h0000_0006, "drained_status");
        wr(A_STAT, 32'h0000_0004);
        rd(A_STAT, 32'h0000_0002, "ovf_cleared");

        // Full FIFO with simultaneous pop and push
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(A_TXD, 32'h10 + 32'(i));
        rd(A_STAT, 32'h0000_0081, "full_status");
        tx_ready = 1'b1;
        wr(A_TXD, 32'h0000_00AA);
        tx_ready = 1'b0;
        rd(A_STAT, 32'h0000_0081, "full_pushpop_status");
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, "pushpop_drain");
        chk("pushpop_left", 32'(exp_tx.size()), 32'h0);
        rd(A_STAT, 32'h0000_0002, "pushpop_empty");

        // Cycle counter load and wrap, switch synchronizer latency
        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC, 32'hFFFF_FFFE, "cycle_load");
        rd(A_CYC, 32'hFFFF_FFFF, "cycle_inc");
        rd(A_CYC, 32'h0000_0000, "cycle_wrap");
        sw_in = 16'hA5C3;
        rd(A_SW, 32'h0, "sw_old0");
        rd(A_SW, 32'h0, "sw_old1");
        rd(A_SW, 32'h0000_A5C3, "sw_new0");
        rd(A_SW, 32'h0000_A5C3, "sw_new1");

        // Asynchronous reset mid-run
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(A_TXD, 32'h30 + 32'(i));
        wr(A_LED, 32'h0000_00FF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("async_led", {16'h0, led_out}, 32'h0);
        chk("async_tx_data", {24'h0, tx_data}, 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rd(32'h0000_0040, 32'hDEAD_BEEF, "ram_after_reset");
        rd(A_STAT, 32'h0000_0002, "status_after_reset");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            global_en  = ($urandom_range(0, 4) != 0);
            dmem_we    = $urandom_range(0, 1);
            tx_ready   = ($urandom_range(0, 2) == 0);
            dmem_wdata = $urandom;
            if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
            if ($urandom_range(0, 7) < 3) begin
                dmem_addr = {16'($urandom_range(0, 32'hFFFE)), 4'($urandom),
                             10'(16 + $urandom_range(0, 3)), 2'($urandom)};
            end else begin
                dmem_addr = {16'hFFFF, 8'($urandom),
                             offs[$urandom_range(0, 5)] | 8'($urandom_range(0, 3))};
            end
            step(1'b0, 32'h0, "rnd_rd");
        end
        dmem_we  = 1'b0;
        tx_ready = 1'b1;
        repeat (10) step(1'b0, 32'h0, "final_drain");
        chk("final_left", 32'(exp_tx.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
